minterm_scanner: RTL and testbench
==================================

// Module: minterm_scanner
// PURPOSE
//  Sequential stimulus/capture stage driving the 4-input decoder-tree function block (F = f(A,B,C,D)).
//  On start, steps {A,B,C,D} through all 2^N_IN input codes and lets each settle for SETTLE cycles.
//  Samples F per code into a truth-table register, then compares it with the expected minterm mask.
//  Sits directly upstream of the function block (abcd_out -> A,B,C,D) and consumes its F output.
// PARAMETERS
//  N_IN      4         number of function inputs; table width is 2^N_IN
//  SETTLE    1         extra cycles each code is held before F is sampled (0 allowed)
//  EXPECTED  16'h0DE0  expected truth table, bit i = F(i); default = sum m(5,6,7,8,10,11)
// PORTS
//  clk        in   1         single clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  start      in   1         scan request; sampled only in IDLE
//  f_in       in   1         F output of the function block
//  abcd_out   out  N_IN      code under test, MSB = A, LSB = D
//  busy       out  1         high from the cycle after start acceptance until done
//  done       out  1         one-cycle pulse when table_out and match are final
//  table_out  out  2^N_IN    captured truth table, bit i = F sampled with abcd_out==i
//  match      out  1         table_out == EXPECTED; valid from done, held until next start
// BEHAVIOUR
//  Clock and reset:
//  - One clock: clk.
//  - Reset is asynchronous and active-low: rst_n.
//  Reset values:
//  - state = IDLE.
//  - abcd_out, busy, done, table_out, match and the internal cnt/idx all reset to 0.
//  States:
//  - IDLE: start=1 moves to DRIVE at the next edge; idx=0, cnt=0, table_out cleared, match cleared.
//  - DRIVE: abcd_out=idx, busy=1.
//    - If cnt < SETTLE: cnt++.
//    - Else (cnt==SETTLE), at that edge: table_out[idx] <= f_in.
//      - If idx == 2^N_IN-1, go to DONE.
//      - Otherwise idx++ and cnt=0.
//  - DONE: done=1 and busy=0 for exactly one cycle, match <= (table_out == EXPECTED); next state IDLE.
//  Timing:
//  - Each code is held on abcd_out for exactly SETTLE+1 cycles; f_in is sampled at the last edge of that window.
//  - Latency: done is high in cycle (2^N_IN)*(SETTLE+1)+1 after the start-accept edge.
//    With defaults that is cycle 33; with SETTLE=0 it is cycle 17.
//  - match uses the fully updated table, including the final sample (compute it combinationally from the next-table value or in DONE).
//  Boundary conditions:
//  - start while busy or in DONE is ignored; no queuing.
//  - start held high continuously gives back-to-back scans with one IDLE cycle between done and the next busy.
//  - idx never wraps mid-scan; the terminal compare is on 2^N_IN-1.
//  - After done, abcd_out holds the last code until the next start.
//  - rst_n low mid-scan immediately forces all reset values; there is no partial result and no done pulse.
//  - f_in is treated as synchronous to clk; no synchronizer is provided.
// STRUCTURE
//  Shared package/include:
//  - state encodings IDLE=2'd0, DRIVE=2'd1, DONE=2'd2.
//  - the default EXPECTED minterm mask constant, shared with the function-block bench.
//  Sub-module:
//  - settle_counter: cnt register plus terminal flag (cnt==SETTLE).
//  - FSM, idx and table capture stay in minterm_scanner.
// TESTING
//  T1 Golden: DUT wired to the decoder-tree block, defaults, start pulse.
//     -> abcd_out 0..15, each held 2 cycles; done in cycle 33; table_out=16'h0DE0, match=1.
//  T2 Fault: f_in tied 0.
//     -> table_out=16'h0000, match=0, done still in cycle 33.
//  T3 Ignored start: start pulsed again in cycles 5 and 33.
//     -> no restart, single done; table_out is unchanged by those pulses.
//  T4 Reset mid-scan: rst_n low in cycle 10 with start held.
//     -> abcd_out=0, busy=0, table_out=0 immediately; a fresh scan after release completes normally.
//  T5 SETTLE=0 with an f_in model equal to abcd_out[0].
//     -> each code held 1 cycle; done in cycle 17; table_out=16'hAAAA, match=0.
//  T6 start held high across two scans.
//     -> two done pulses 34 cycles apart; match=1 both times.

Source files
------------

// File: rtl/minterm_scanner_pkg.sv
// Shared definitions for the minterm scanner and the decoder-tree function-block bench.
// Holds the FSM encoding, the default expected truth table and the settle-counter width rule.
package minterm_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // sum m(5,6,7,8,10,11): bit i = F(i)
    localparam logic [15:0] EXPECTED_DEFAULT = 16'h0DE0;

    function automatic int cnt_width(input int settle);
        return (settle < 2) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/minterm_scanner_settle_counter.sv
// Purpose: per-code hold counter; term flags the final cycle of a code's settle window.
// Latency: term is combinational from the registered count; count updates one edge after inc/clr.
// Backpressure: none; clr wins over inc.
module minterm_scanner_settle_counter
    import minterm_scanner_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int CW     = cnt_width(SETTLE)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic term
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign term = (cnt == CW'(SETTLE));

endmodule

// File: rtl/minterm_scanner.sv
// Purpose: walks all 2^N_IN input codes into the function block, captures F per code, checks the table.
// Latency: done pulses (2^N_IN)*(SETTLE+1)+1 cycles after the start-accept edge.
// Backpressure: none; start is only honoured in IDLE, requests while busy or done are dropped.
module minterm_scanner
    import minterm_scanner_pkg::*;
#(
    parameter int                     N_IN     = 4,
    parameter int                     SETTLE   = 1,
    parameter logic [(2**N_IN)-1:0]   EXPECTED = EXPECTED_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    f_in,
    output logic [N_IN-1:0]         abcd_out,
    output logic                    busy,
    output logic                    done,
    output logic [(2**N_IN)-1:0]    table_out,
    output logic                    match
);

    localparam int TW = 2**N_IN;

    state_t          state;
    logic [N_IN-1:0] idx;
    logic            term;
    logic            accept;
    logic            cnt_clr;
    logic            cnt_inc;
    logic [TW-1:0]   table_nxt;

    assign accept  = (state == IDLE) && start;
    assign cnt_clr = accept || ((state == DRIVE) && term);
    assign cnt_inc = (state == DRIVE) && !term;

    minterm_scanner_settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .term  (term)
    );

    // The final sample must be part of the table that match is computed from.
    always_comb begin
        table_nxt      = table_out;
        table_nxt[idx] = f_in;
    end

    assign abcd_out = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
            match     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= DRIVE;
                        idx       <= '0;
                        busy      <= 1'b1;
                        table_out <= '0;
                        match     <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (term) begin
                        table_out <= table_nxt;
                        if (idx == {N_IN{1'b1}}) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            match <= (table_nxt == EXPECTED);
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minterm_scanner.sv
// Bench for minterm_scanner: default instance driven from a truth-table model of the function block,
// plus a SETTLE=0 instance whose F follows abcd_out[0].
module tb_minterm_scanner;
    import minterm_scanner_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [15:0] ftbl;
    logic        f_a, f_b;
    logic [3:0]  abcd_a, abcd_b;
    logic        busy_a, busy_b, done_a, done_b, match_a, match_b;
    logic [15:0] tbl_a, tbl_b;

    int checks   = 0;
    int failures = 0;

    logic [15:0] golden;
    logic [3:0]  o_abcd  [0:99];
    logic        o_busy  [0:99];
    logic        o_done  [0:99];
    logic        o_match [0:99];
    logic [15:0] o_tbl   [0:99];

    always #5 clk = ~clk;

    assign f_a = ftbl[abcd_a];
    assign f_b = abcd_b[0];

    minterm_scanner dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_a),
        .f_in      (f_a),
        .abcd_out  (abcd_a),
        .busy      (busy_a),
        .done      (done_a),
        .table_out (tbl_a),
        .match     (match_a)
    );

    minterm_scanner #(.SETTLE(0)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_b),
        .f_in      (f_b),
        .abcd_out  (abcd_b),
        .busy      (busy_b),
        .done      (done_b),
        .table_out (tbl_b),
        .match     (match_b)
    );

    // Reference: code k-th cycle after accept is held hold=settle+1 cycles, last code persists.
    function automatic int exp_code(input int k, input int settle);
        int hold;
        hold = settle + 1;
        if (k > 16 * hold) return 15;
        return (k - 1) / hold;
    endfunction

    function automatic logic exp_busy(input int k, input int settle);
        return (k >= 1) && (k <= 16 * (settle + 1));
    endfunction

    task automatic accept(input bit sel, input bit hold);
        @(negedge clk);
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            start_a = 1'b0;
            start_b = 1'b0;
        end
    endtask

    // Records outputs for cycles 1..n after the accept edge; optional start pulses at cycles p1/p2.
    task automatic observe(input bit sel, input int n, input int p1, input int p2);
        for (int k = 1; k <= n; k++) begin
            if (p1 != 0 || p2 != 0) start_a = (k == p1) || (k == p2);
            o_abcd[k]  = sel ? abcd_b  : abcd_a;
            o_busy[k]  = sel ? busy_b  : busy_a;
            o_done[k]  = sel ? done_b  : done_a;
            o_match[k] = sel ? match_b : match_a;
            o_tbl[k]   = sel ? tbl_b   : tbl_a;
            @(posedge clk);
            #1;
        end
        if (p1 != 0 || p2 != 0) start_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        ftbl    = 16'h0000;
        #12;
        checks++;
        if ({abcd_a, busy_a, done_a, match_a, tbl_a} !== 23'd0) begin
            failures++;
            $display("FAIL reset_a got abcd=%0d busy=%b done=%b match=%b table=%h want all zero",
                     abcd_a, busy_a, done_a, match_a, tbl_a);
        end
        checks++;
        if ({abcd_b, busy_b, done_b, match_b, tbl_b} !== 23'd0) begin
            failures++;
            $display("FAIL reset_b got abcd=%0d busy=%b done=%b match=%b table=%h want all zero",
                     abcd_b, busy_b, done_b, match_b, tbl_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_golden();
        ftbl = golden;
        accept(0, 0);
        observe(0, 40, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            checks++;
            if (o_abcd[k] !== 4'(exp_code(k, 1)) || o_busy[k] !== exp_busy(k, 1) ||
                o_done[k] !== (k == 33)) begin
                failures++;
                $display("FAIL golden_seq k=%0d got code=%0d busy=%b done=%b want code=%0d busy=%b done=%b",
                         k, o_abcd[k], o_busy[k], o_done[k], exp_code(k, 1), exp_busy(k, 1), (k == 33));
            end
        end
        checks++;
        if (o_tbl[33] !== golden || o_match[33] !== 1'b1) begin
            failures++;
            $display("FAIL golden_result got table=%h match=%b want table=%h match=1", o_tbl[33], o_match[33], golden);
        end
        checks++;
        if (o_match[40] !== 1'b1 || o_tbl[40] !== golden) begin
            failures++;
            $display("FAIL golden_hold got table=%h match=%b want table=%h match=1", o_tbl[40], o_match[40], golden);
        end
    endtask

    task automatic test_fault();
        int ndone;
        int first;
        ftbl = 16'h0000;
        accept(0, 0);
        observe(0, 36, 0, 0);
        ndone = 0;
        first = 0;
        for (int k = 1; k <= 36; k++) begin
            if (o_done[k] === 1'b1) begin
                if (ndone == 0) first = k;
                ndone++;
            end
        end
        checks++;
        if (ndone != 1 || first != 33) begin
            failures++;
            $display("FAIL fault_done got count=%0d first=%0d want count=1 first=33", ndone, first);
        end
        checks++;
        if (o_tbl[33] !== 16'h0000 || o_match[33] !== 1'b0) begin
            failures++;
            $display("FAIL fault_result got table=%h match=%b want table=0000 match=0", o_tbl[33], o_match[33]);
        end
    endtask

    task automatic test_ignored_start();
        int ndone;
        int first;
        int busy_after;
        ftbl = 16'($urandom);
        accept(0, 0);
        observe(0, 45, 5, 33);
        ndone = 0;
        first = 0;
        busy_after = 0;
        for (int k = 1; k <= 45; k++) begin
            if (o_done[k] === 1'b1) begin
                if (ndone == 0) first = k;
                ndone++;
            end
            if (k > 33 && o_busy[k] !== 1'b0) busy_after++;
        end
        checks++;
        if (ndone != 1 || first != 33 || busy_after != 0) begin
            failures++;
            $display("FAIL ignored_start got done_count=%0d first=%0d busy_after=%0d want 1 33 0",
                     ndone, first, busy_after);
        end
        checks++;
        if (o_tbl[33] !== ftbl || o_tbl[45] !== ftbl || o_match[33] !== (ftbl == golden)) begin
            failures++;
            $display("FAIL ignored_table got t33=%h t45=%h match=%b want table=%h match=%b",
                     o_tbl[33], o_tbl[45], o_match[33], ftbl, (ftbl == golden));
        end
        checks++;
        if (o_abcd[45] !== 4'd15) begin
            failures++;
            $display("FAIL ignored_last_code got=%0d want=15", o_abcd[45]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            if (i == 0)      ftbl = golden;
            else if (i == 3) ftbl = golden ^ (16'd1 << $urandom_range(15));
            else             ftbl = 16'($urandom);
            accept(0, 0);
            observe(0, 34, 0, 0);
            checks++;
            if (o_done[33] !== 1'b1 || o_tbl[33] !== ftbl || o_match[33] !== (ftbl == golden)) begin
                failures++;
                $display("FAIL random_%0d got done=%b table=%h match=%b want done=1 table=%h match=%b",
                         i, o_done[33], o_tbl[33], o_match[33], ftbl, (ftbl == golden));
            end
        end
    endtask

    task automatic test_reset_midscan();
        logic [15:0] partial;
        int          idle_busy;
        ftbl = 16'hFFFF;
        accept(0, 1);
        observe(0, 9, 0, 0);
        // codes sampled before cycle 9: (9-1)/(SETTLE+1) of them
        partial = ftbl & ((16'd1 << ((9 - 1) / 2)) - 16'd1);
        checks++;
        if (o_tbl[9] !== partial || o_busy[9] !== 1'b1) begin
            failures++;
            $display("FAIL midscan_partial got table=%h busy=%b want table=%h busy=1", o_tbl[9], o_busy[9], partial);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({abcd_a, busy_a, done_a, match_a, tbl_a} !== 23'd0) begin
            failures++;
            $display("FAIL midscan_reset got abcd=%0d busy=%b done=%b match=%b table=%h want all zero",
                     abcd_a, busy_a, done_a, match_a, tbl_a);
        end
        start_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        observe(0, 5, 0, 0);
        idle_busy = 0;
        for (int k = 1; k <= 5; k++) if (o_busy[k] !== 1'b0 || o_done[k] !== 1'b0) idle_busy++;
        checks++;
        if (idle_busy != 0) begin
            failures++;
            $display("FAIL midscan_quiet got active_cycles=%0d want 0", idle_busy);
        end
        ftbl = golden;
        accept(0, 0);
        observe(0, 34, 0, 0);
        checks++;
        if (o_done[33] !== 1'b1 || o_tbl[33] !== golden || o_match[33] !== 1'b1) begin
            failures++;
            $display("FAIL midscan_rescan got done=%b table=%h match=%b want done=1 table=%h match=1",
                     o_done[33], o_tbl[33], o_match[33], golden);
        end
    endtask

    task automatic test_settle0();
        logic [15:0] want;
        want = '0;
        for (int i = 0; i < 16; i++) want[i] = (i % 2 == 1);
        accept(1, 0);
        observe(1, 20, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            checks++;
            if (o_abcd[k] !== 4'(exp_code(k, 0)) || o_busy[k] !== exp_busy(k, 0) ||
                o_done[k] !== (k == 17)) begin
                failures++;
                $display("FAIL settle0_seq k=%0d got code=%0d busy=%b done=%b want code=%0d busy=%b done=%b",
                         k, o_abcd[k], o_busy[k], o_done[k], exp_code(k, 0), exp_busy(k, 0), (k == 17));
            end
        end
        checks++;
        if (o_tbl[17] !== want || o_match[17] !== (want == golden)) begin
            failures++;
            $display("FAIL settle0_result got table=%h match=%b want table=%h match=%b",
                     o_tbl[17], o_match[17], want, (want == golden));
        end
    endtask

    task automatic test_back_to_back();
        int dq[$];
        int extra;
        ftbl = golden;
        accept(0, 1);
        observe(0, 67, 0, 0);
        start_a = 1'b0;
        for (int k = 1; k <= 67; k++) if (o_done[k] === 1'b1) dq.push_back(k);
        checks++;
        if (dq.size() != 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=2", dq.size());
        end else begin
            checks++;
            if (dq[0] != 33 || dq[1] - dq[0] != 34 || o_match[dq[0]] !== 1'b1 || o_match[dq[1]] !== 1'b1) begin
                failures++;
                $display("FAIL b2b_pulses got first=%0d gap=%0d m1=%b m2=%b want 33 34 1 1",
                         dq[0], dq[1] - dq[0], o_match[dq[0]], o_match[dq[1]]);
            end
        end
        checks++;
        if (o_busy[34] !== 1'b0 || o_busy[35] !== 1'b1 || o_abcd[35] !== 4'd0) begin
            failures++;
            $display("FAIL b2b_gap got busy34=%b busy35=%b code35=%0d want 0 1 0", o_busy[34], o_busy[35], o_abcd[35]);
        end
        observe(0, 4, 0, 0);
        extra = 0;
        for (int k = 1; k <= 4; k++) if (o_busy[k] !== 1'b0) extra++;
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL b2b_stop got busy_cycles=%0d want 0", extra);
        end
    endtask

    initial begin
        int mts[6];
        mts = '{5, 6, 7, 8, 10, 11};
        golden = '0;
        for (int i = 0; i < 6; i++) golden[mts[i]] = 1'b1;
        test_reset();
        test_golden();
        test_fault();
        test_ignored_start();
        test_random();
        test_reset_midscan();
        test_settle0();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
